// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, stall encoding,
// one-hot ALU operation bit positions and the divider state encoding.
package ex_stage_pkg;

  localparam int STALL_BUS    = 6;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int EX_TO_RF_WD  = 38;
  localparam int DIV_ITER     = 32;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] FUNC_DIV  = 6'h1A;
  localparam logic [5:0] FUNC_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_inst(input logic [31:0] inst);
    return (inst[31:26] == 6'd0) &&
           ((inst[5:0] == FUNC_DIV) || (inst[5:0] == FUNC_DIVU));
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU driven by a one-hot operation vector; all-zero op gives 0.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [4:0] sa;
  assign sa = src1[4:0];

  always_comb begin
    result = 32'd0;
    if (alu_op[ALU_ADD])  result = result | (src1 + src2);
    if (alu_op[ALU_SUB])  result = result | (src1 - src2);
    if (alu_op[ALU_SLT])  result = result | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[ALU_SLTU]) result = result | {31'd0, src1 < src2};
    if (alu_op[ALU_AND])  result = result | (src1 & src2);
    if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
    if (alu_op[ALU_OR])   result = result | (src1 | src2);
    if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
    if (alu_op[ALU_SLL])  result = result | (src2 << sa);
    if (alu_op[ALU_SRL])  result = result | (src2 >> sa);
    if (alu_op[ALU_SRA])  result = result | 32'($signed(src2) >>> sa);
    if (alu_op[ALU_LUI])  result = result | {src2[15:0], 16'd0};
  end

endmodule

// File: rtl/ex_stage_div_iter.sv
// Radix-2 restoring divider: one IDLE latch cycle, 32 shift-subtract cycles,
// then DONE holds the sign-corrected result until the stage may advance.
module ex_stage_div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        advance,
  output logic        stallreq,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic [31:0] abs1, abs2;
  logic [32:0] rem_shift;
  logic [33:0] diff;
  logic        unused_div;

  assign abs1      = (is_signed && op1[31]) ? -op1 : op1;
  assign abs2      = (is_signed && op2[31]) ? -op2 : op2;
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dsr_q};
  assign unused_div = ^{rem_shift[32], diff[32]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    stallreq  = 1'b0;
    ready     = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          stallreq  = 1'b1;
          quo_d     = abs1;
          rem_d     = 32'd0;
          dsr_d     = abs2;
          cnt_d     = 5'd0;
          neg_quo_d = is_signed & (op1[31] ^ op2[31]);
          neg_rem_d = is_signed & op1[31];
          state_d   = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stallreq = 1'b1;
        // A non-negative trial difference means the divisor fits: keep it.
        if (!diff[33]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        ready = 1'b1;
        if (advance) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dsr_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, ALU, data-SRAM request, forwarding
// and load-hazard info for decode, and the stalling DIV/DIVU unit.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    inst_is_load,
  output logic                    stallreq_for_ex
);

  logic [ID_TO_EX_WD-1:0] id_bus_q, id_bus_d;

  always_comb begin
    id_bus_d = id_bus_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) id_bus_d = '0;
    else if (stall[2] == NO_STOP)                 id_bus_d = id_to_ex_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) id_bus_q <= '0;
    else     id_bus_q <= id_bus_d;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc         = id_bus_q[158:127];
  assign inst       = id_bus_q[126:95];
  assign alu_op     = id_bus_q[94:83];
  assign sel_src1   = id_bus_q[82:80];
  assign sel_src2   = id_bus_q[79:76];
  assign ram_en     = id_bus_q[75];
  assign ram_wen    = id_bus_q[74:71];
  assign rf_we      = id_bus_q[70];
  assign rf_waddr   = id_bus_q[69:65];
  assign sel_rf_res = id_bus_q[64];
  assign rdata1     = id_bus_q[63:32];
  assign rdata2     = id_bus_q[31:0];

  logic [31:0] imm_sext, imm_zext, src1, src2, ex_result;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'd0, inst[15:0]};

  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & imm_zext);

  ex_stage_alu u_alu (
    .alu_op (alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (ex_result)
  );

  logic        div_ready;
  logic [31:0] div_quo, div_rem;

  ex_stage_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div_inst(inst)),
    .is_signed (inst[5:0] == FUNC_DIV),
    .op1       (rdata1),
    .op2       (rdata2),
    .advance   (stall[2] == NO_STOP),
    .stallreq  (stallreq_for_ex),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  logic [31:0] hi, lo;
  assign hi = div_ready ? div_rem : 32'd0;
  assign lo = div_ready ? div_quo : 32'd0;

  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr,
                          ex_result, div_ready, hi, lo};
  assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

  // Loads forward their address here; decode must stall on inst_is_load.
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = rdata1 + imm_sext;
  assign data_sram_wdata = rdata2;
  assign inst_is_load    = ram_en & (ram_wen == 4'd0);

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule
